cas_tape_player: RTL and testbench

//  Cassette image player for the HT1080Z core. Captures a .CAS image from the HPS download

---
 rtl/cas_pkg.sv | 20 ++
 rtl/cas_ram.sv | 25 ++
 rtl/cas_tape_player.sv | 139 +++++++++++++
 tb/tb_cas_tape_player.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_pkg.sv
// Shared types and defaults for the cassette image player.
package cas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    PLAY  = 3'd4
  } cas_state_t;

  localparam int unsigned DEF_BIT_CYC = 84000;
  localparam int unsigned HALF_CYC    = DEF_BIT_CYC / 2;

  // Second-pulse position inside a bit cell, for non-default cell lengths.
  function automatic int unsigned half_cyc(input int unsigned bit_cyc);
    return bit_cyc / 2;
  endfunction

endpackage

// File: rtl/cas_ram.sv
// Single-port image store: write-first, one-cycle synchronous read.
module cas_ram
  import cas_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        q
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      q         <= wdata;
    end else begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/cas_tape_player.sv
// Captures a .CAS image from the HPS download stream and replays it as a
// TRS-80 Level II 500-baud pulse train.
module cas_tape_player
  import cas_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BIT_CYC   = 84000,
  parameter int unsigned PULSE_CYC = 5250
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_go,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic [7:0]        dn_idx,
  input  logic              play,
  input  logic              stop,
  output logic              cas_out,
  output logic              busy,
  output logic              loaded,
  output logic [ADDR_W:0]   length
);

  localparam int unsigned PH_W = $clog2(BIT_CYC);
  localparam logic [PH_W-1:0] PULSE_P    = PH_W'(PULSE_CYC);
  localparam logic [PH_W-1:0] HALF_P     = PH_W'(half_cyc(BIT_CYC));
  localparam logic [PH_W-1:0] HALF_END_P = PH_W'(half_cyc(BIT_CYC) + PULSE_CYC);
  localparam logic [PH_W-1:0] LAST_P     = PH_W'(BIT_CYC - 1);

  cas_state_t      state;
  logic            sel, sel_prev, play_prev;
  logic            sel_rise, sel_fall, play_rise;
  logic [ADDR_W:0] ptr, ptr_inc, wr_len;
  logic [7:0]      shreg, ram_q;
  logic [2:0]      bit_idx;
  logic [PH_W-1:0] phase;
  logic            ram_we, cell_bit, pulse;
  logic [ADDR_W-1:0] ram_addr;

  always_comb begin
    sel       = dn_go && (dn_idx != 8'd0);
    sel_rise  = sel && !sel_prev;
    sel_fall  = !sel && sel_prev;
    play_rise = play && !play_prev;
    ram_we    = (state == LOAD) && sel && dn_wr;
    ram_addr  = (state == LOAD) ? dn_addr : ptr[ADDR_W-1:0];
    // Length is one bit wider than the address so a full image reads 2**ADDR_W.
    wr_len    = {1'b0, dn_addr} + (ADDR_W + 1)'(1);
    ptr_inc   = ptr + (ADDR_W + 1)'(1);
    cell_bit  = shreg[bit_idx];
    pulse     = (phase < PULSE_P) ||
                (cell_bit && (phase >= HALF_P) && (phase < HALF_END_P));
    busy      = (state == FETCH) || (state == WAIT) || (state == PLAY);
  end

  cas_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_sys),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (dn_data),
    .q     (ram_q)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_prev  <= 1'b0;
      play_prev <= 1'b0;
      cas_out   <= 1'b0;
      loaded    <= 1'b0;
      length    <= '0;
      ptr       <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      phase     <= '0;
    end else begin
      sel_prev  <= sel;
      play_prev <= play;
      // A new capture pre-empts everything, including stop and an active playback.
      if (sel_rise) begin
        state   <= LOAD;
        length  <= '0;
        loaded  <= 1'b0;
        cas_out <= 1'b0;
      end else if (state == LOAD) begin
        if (sel_fall) begin
          state  <= IDLE;
          loaded <= (length != '0);
        end else if (ram_we && (wr_len > length)) begin
          length <= wr_len;
        end
      end else if (stop) begin
        state   <= IDLE;
        cas_out <= 1'b0;
        ptr     <= '0;
      end else begin
        case (state)
          IDLE: begin
            cas_out <= 1'b0;
            if (play_rise && loaded) begin
              state <= FETCH;
              ptr   <= '0;
            end
          end
          FETCH: begin
            cas_out <= 1'b0;
            state   <= WAIT;
          end
          WAIT: begin
            cas_out <= 1'b0;
            shreg   <= ram_q;
            bit_idx <= 3'd7;
            phase   <= '0;
            state   <= PLAY;
          end
          PLAY: begin
            cas_out <= pulse;
            if (phase == LAST_P) begin
              phase <= '0;
              if (bit_idx != 3'd0) begin
                bit_idx <= bit_idx - 3'd1;
              end else begin
                ptr   <= ptr_inc;
                state <= (ptr_inc == length) ? IDLE : FETCH;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cas_tape_player.sv
// Randomised bench for cas_tape_player against a waveform-queue reference model.
module tb_cas_tape_player;

  localparam int unsigned AW = 4;
  localparam int unsigned BC = 16;
  localparam int unsigned PC = 2;
  localparam int unsigned HC = BC / 2;
  localparam int unsigned DEPTH = 16;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          dn_go   = 1'b0;
  logic          dn_wr   = 1'b0;
  logic [AW-1:0] dn_addr = '0;
  logic [7:0]    dn_data = '0;
  logic [7:0]    dn_idx  = '0;
  logic          play    = 1'b0;
  logic          stop    = 1'b0;
  logic          cas_out, busy, loaded;
  logic [AW:0]   length;

  cas_tape_player #(
    .ADDR_W    (AW),
    .BIT_CYC   (BC),
    .PULSE_CYC (PC)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .dn_go   (dn_go),
    .dn_wr   (dn_wr),
    .dn_addr (dn_addr),
    .dn_data (dn_data),
    .dn_idx  (dn_idx),
    .play    (play),
    .stop    (stop),
    .cas_out (cas_out),
    .busy    (busy),
    .loaded  (loaded),
    .length  (length)
  );

  always #5 clk_sys = ~clk_sys;

  // One entry per cycle of playback: expected busy and the waveform level that
  // cas_out will show one cycle later (care=0 where the RAM byte is unknown).
  typedef struct packed {
    logic busy;
    logic wave;
    logic care;
  } slot_t;

  slot_t      exp_q[$];
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  int         m_len;
  bit         m_loaded, loading, prev_sel, prev_play;
  logic       last_wave, last_care, last_busy;
  int         n_tests, n_fail;
  int         tmo_cnt, tmo_seen;
  bit         pinned;

  function automatic logic wave_at(input int ph, input logic b);
    return (ph < PC) || (b && ph >= HC && ph < HC + PC);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_stream();
    for (int b = 0; b < m_len; b++) begin
      exp_q.push_back('{1'b1, 1'b0, 1'b1});
      exp_q.push_back('{1'b1, 1'b0, 1'b1});
      for (int k = 7; k >= 0; k--)
        for (int ph = 0; ph < BC; ph++)
          exp_q.push_back('{1'b1, wave_at(ph, m_mem[b][k]), logic'(m_known[b])});
    end
  endtask

  // Hand-derived expectations for the A5,00 image pin the model itself.
  task automatic pin_model();
    if (!pinned && m_len == 2 && m_mem[0] == 8'hA5 && m_mem[1] == 8'h00) begin
      pinned = 1'b1;
      check("pin_len",     exp_q.size(), 260);
      check("pin_fetch",   int'(exp_q[0].wave), 0);
      check("pin_c0_ph0",  int'(exp_q[2].wave), 1);
      check("pin_c0_ph2",  int'(exp_q[4].wave), 0);
      check("pin_c0_ph8",  int'(exp_q[10].wave), 1);
      check("pin_c0_ph10", int'(exp_q[12].wave), 0);
      check("pin_c1_ph0",  int'(exp_q[18].wave), 1);
      check("pin_c1_ph8",  int'(exp_q[26].wave), 0);
      check("pin_c2_ph8",  int'(exp_q[42].wave), 1);
      check("pin_b1_ph0",  int'(exp_q[132].wave), 1);
      check("pin_b1_ph8",  int'(exp_q[140].wave), 0);
      check("pin_last",    int'(exp_q[259].busy), 1);
    end
  endtask

  // Inputs change 1 time unit after a falling edge, so at each falling edge the
  // model sees exactly what the DUT sampled on the rising edge just passed.
  always @(negedge clk_sys) begin
    slot_t s;
    bit    flush, sel;
    int    a;
    flush = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_len = 0; m_loaded = 0; loading = 0; prev_sel = 0; prev_play = 0; last_busy = 0;
      flush = 1'b1;
    end else begin
      sel = dn_go && (dn_idx != 8'd0);
      if (sel && !prev_sel) begin
        exp_q.delete();
        m_len = 0; m_loaded = 0; loading = 1; flush = 1'b1;
      end else if (loading) begin
        if (!sel) begin
          loading  = 0;
          m_loaded = (m_len != 0);
        end else if (dn_wr) begin
          a = int'(dn_addr);
          m_mem[a] = dn_data;
          m_known[a] = 1'b1;
          if (a + 1 > m_len) m_len = a + 1;
        end
      end else if (stop) begin
        exp_q.delete();
        flush = 1'b1;
      end else if (!last_busy && play && !prev_play && m_loaded) begin
        build_stream();
        pin_model();
      end
      prev_sel  = sel;
      prev_play = play;
    end
    if (exp_q.size() != 0) s = exp_q.pop_front();
    else s = '{1'b0, 1'b0, 1'b1};
    check("busy", int'(busy), int'(s.busy));
    if (flush) check("cas_out", int'(cas_out), 0);
    else if (last_care) check("cas_out", int'(cas_out), int'(last_wave));
    check("loaded", int'(loaded), int'(m_loaded));
    check("length", int'(length), m_len);
    if (tmo_cnt != tmo_seen) begin
      check("wait_idle", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
    last_wave = s.wave;
    last_care = s.care;
    last_busy = s.busy;
  end

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic dl_start(input logic [7:0] idx);
    dn_idx = idx;
    dn_go  = 1'b1;
    step();
  endtask

  task automatic dl_wr(input int a, input logic [7:0] d);
    dn_addr = AW'(a);
    dn_data = d;
    dn_wr   = 1'b1;
    step();
    dn_wr   = 1'b0;
  endtask

  task automatic dl_end();
    dn_wr = 1'b0;
    dn_go = 1'b0;
    steps(2);
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step();
    play = 1'b0;
    step();
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    if (busy) tmo_cnt++;
    step();
  endtask

  task automatic dl_full_shuffled(input logic [7:0] idx, input int len);
    int order [DEPTH];
    int j, t;
    for (int i = 0; i < DEPTH; i++) order[i] = i;
    for (int i = len - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    dl_start(idx);
    for (int i = 0; i < len; i++) dl_wr(order[i], 8'($urandom));
    dl_end();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; tmo_cnt = 0; tmo_seen = 0; pinned = 1'b0;
    last_wave = 1'b0; last_care = 1'b1; last_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 8'h00;
      m_known[i] = 1'b0;
    end
    steps(3);
    reset = 1'b0;
    step();

    // No image yet: play is ignored; ROM-index writes do nothing.
    pulse_play();
    dl_start(8'd0);
    for (int i = 0; i < 3; i++) dl_wr(i, 8'hFF);
    dl_end();
    pulse_play();
    steps(4);

    // A5,00 image, full playback.
    dl_start(8'd1);
    dl_wr(0, 8'hA5);
    dl_wr(1, 8'h00);
    dl_end();
    pulse_play();
    wait_idle(3000);

    // Reset mid-playback, then a play pulse that must be ignored.
    pulse_play();
    steps(40);
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    step();
    pulse_play();
    steps(20);

    // Full 16-byte image written in order: no wrap after byte 15.
    dl_start(8'd3);
    for (int i = 0; i < 16; i++) dl_wr(i, 8'($urandom));
    dl_end();
    pulse_play();
    wait_idle(3000);
    steps(10);

    // Out-of-order writes; cells 0,1,3,4 replay what the RAM already holds.
    dl_start(8'd2);
    dl_wr(5, 8'($urandom));
    dl_wr(2, 8'($urandom));
    dl_end();
    pulse_play();
    wait_idle(3000);

    // Stop during playback, then restart from byte 0.
    pulse_play();
    steps(18);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    pulse_play();
    wait_idle(3000);

    // Play and stop together: stop wins.
    play = 1'b1;
    stop = 1'b1;
    step();
    play = 1'b0;
    stop = 1'b0;
    steps(3);

    // New capture mid-playback aborts it; then a full shuffled image.
    pulse_play();
    steps(300);
    dl_full_shuffled(8'd1, 16);
    pulse_play();
    wait_idle(3000);

    // Capture rise and play edge together: capture wins.
    dn_idx = 8'd4;
    dn_go  = 1'b1;
    play   = 1'b1;
    step();
    play   = 1'b0;
    dl_wr(0, 8'($urandom));
    dl_end();
    pulse_play();
    wait_idle(3000);

    // Random images, with an occasional random stop.
    for (int r = 0; r < 4; r++) begin
      dl_full_shuffled(8'($urandom_range(255, 1)), int'($urandom_range(16, 1)));
      pulse_play();
      if ($urandom_range(1, 0) == 1) begin
        steps(int'($urandom_range(400, 1)));
        stop = 1'b1;
        step();
        stop = 1'b0;
      end
      wait_idle(3000);
    end

    steps(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
